gpio_bank: RTL
==============

// Module: gpio_bank
// PURPOSE
//  Parametrised N-pin GPIO bank; successor to the single-pin GPIO controller.
//  Per-pin mode mux (input/totem/open-drain/wired-or/debug/PWM), synchronised
//  and debounced input path, and edge-triggered interrupt status with
//  sticky bits. Sits between the register file and the IO pads.
// PARAMETERS
//  N_PINS   8  number of GPIO pins in the bank
//  N_PWM    8  number of PWM sources available; cfg 8+k selects pwm_pin[k]
//  DB_BITS  4  debounce counter width; DB_MAX = 2**DB_BITS-1
// PORTS
//  reset       in     1          asynchronous, active-high reset
//  clk         in     1          clock
//  gpio_pin    inout  N_PINS     pads
//  pin_ctrl    in     N_PINS     per-pin drive value
//  pin_cfg     in     4*N_PINS   per-pin mode; pin i uses [4i+3:4i]
//  pwm_pin     in     N_PWM      PWM sources
//  dbg_pin     in     1          debug source, shared by all pins
//  db_en       in     N_PINS     1 = debounce enabled for that pin
//  irq_en      in     N_PINS     per-pin interrupt enable
//  irq_mode    in     2*N_PINS   01 rise, 10 fall, 11 both, 00 none
//  irq_clr     in     N_PINS     1-cycle pulse, clears irq_stat bit
//  pin_status  out    N_PINS     synchronised/debounced pad value
//  irq_stat    out    N_PINS     sticky edge status
//  irq         out    1          registered OR of irq_stat
// BEHAVIOUR
//  Reset: oe_l=1 (all pins Hi-Z), out=0, sync flops=0, pin_status=0,
//   debounce cnt=0, irq_stat=0, irq=0. Reset mid-operation aborts any
//   pending debounce and drops all drive within the same clock.
//  Output path (per pin): pin_cfg/pin_ctrl registered once (_p1), then
//   oe_l/out registered again. Latency is 2 clk from input change to pad.
//   cfg 0 in (oe_l=1,out=0); 1 totem (oe_l=0,out=ctrl); 2 open-drain
//   (oe_l=ctrl,out=0); 3 wired-or (oe_l=~ctrl,out=1); 4-6 Hi-Z (oe_l=1,out=1);
//   7 drive dbg_pin; 8-15 drive pwm_pin[cfg-8].
//   If cfg-8 >= N_PWM, the pin drives 0 (oe_l=0).
//  Input path: 2-flop synchroniser (s2), then debounce:
//   db_en=0: pin_status <= s2 every clk. Pad to pin_status = 3 clk.
//   db_en=1: if s2==pin_status, cnt<=0.
//     Else if cnt==DB_MAX, pin_status<=s2 and cnt<=0.
//     Else cnt<=cnt+1.
//     Pad to pin_status = DB_MAX+3 clk for a stable level.
//     Any glitch shorter than DB_MAX+1 clk is ignored.
//   Toggling db_en mid-count is legal. db_en=0 updates immediately and
//   zeroes cnt.
//  Edge detect: st_p1 <= pin_status. rise = pin_status & ~st_p1,
//   fall = ~pin_status & st_p1. Qualified by irq_mode and irq_en.
//   irq_stat bit sets 1 clk after the pin_status change.
//   Set and irq_clr in the same clk: set wins (no lost edge).
//   irq_en=0 blocks new sets but does not clear existing bits.
//  irq <= |irq_stat, so irq follows irq_stat by 1 clk.
//  The post-reset 0->1 on a high pad is a real rise edge. Software must
//   clear irq_stat before enabling irq_en.
//  The pin's own output is observed on pin_status (loopback via the pad).
// STRUCTURE
//  Shared include gpio_defs.vh: CFG_IN/TOTEM/OD/WOR/DBG/PWM0 localparams,
//   IRQ_RISE/FALL/BOTH codes.
//  Sub-module gpio_pin_slice holds one pin: iob_bidi, mode mux, sync,
//   debounce, edge detect and irq_stat bit. Instantiate it N_PINS times
//   in a generate loop. The top holds only the irq OR register.
// TESTING
//  1 Reset: all pads Hi-Z, outputs 0. Assert reset mid-debounce: pin_status
//    holds 0 and cnt restarts after release.
//  2 Modes: cfg=1, ctrl=1 -> pad 1 two clk later. cfg=2, ctrl=1 -> Z.
//    cfg=3, ctrl=0 -> Z; cfg=3, ctrl=1 -> 1. cfg=9 -> follows pwm_pin[1].
//    N_PWM=4, cfg=12 -> pad 0.
//  3 Debounce (DB_BITS=4): 10-clk pulse -> no pin_status change, no irq.
//    Stable 0->1 -> pin_status rises exactly 18 clk after the pad.
//    db_en=0 -> rises after 3 clk.
//  4 Irq: mode=01, en=1, pad rise -> irq_stat set at pin_status+1, irq
//    1 clk later. A fall does not set it. mode=11 sets on both edges.
//  5 Clear race: irq_clr pulse coincident with a new edge -> bit stays 1.
//    Clear alone -> bit 0 next clk, irq 0 one clk after.
//  6 Multi-pin (N_PINS=8): independent cfgs on all pins simultaneously, no
//    crosstalk. Edges on pins 0 and 7 in the same clk set both bits.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// Shared mode encodings and interrupt edge qualification for the GPIO bank.
package gpio_bank_pkg;

  localparam logic [3:0] CFG_IN    = 4'd0;
  localparam logic [3:0] CFG_TOTEM = 4'd1;
  localparam logic [3:0] CFG_OD    = 4'd2;
  localparam logic [3:0] CFG_WOR   = 4'd3;
  localparam logic [3:0] CFG_DBG   = 4'd7;
  localparam logic [3:0] CFG_PWM0  = 4'd8;

  typedef enum logic [1:0] {
    IRQ_NONE = 2'b00,
    IRQ_RISE = 2'b01,
    IRQ_FALL = 2'b10,
    IRQ_BOTH = 2'b11
  } irq_mode_e;

  function automatic logic edge_hit(input logic [1:0] mode, input logic rise, input logic fall);
    return (rise && (mode == IRQ_RISE || mode == IRQ_BOTH)) ||
           (fall && (mode == IRQ_FALL || mode == IRQ_BOTH));
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// Register-file side of the GPIO bank: per-pin config in, status and interrupts out.
interface gpio_bank_if #(
  parameter int N_PINS = 8,
  parameter int N_PWM  = 8
);
  logic [N_PINS-1:0]   pin_ctrl;
  logic [4*N_PINS-1:0] pin_cfg;
  logic [N_PWM-1:0]    pwm_pin;
  logic                dbg_pin;
  logic [N_PINS-1:0]   db_en;
  logic [N_PINS-1:0]   irq_en;
  logic [2*N_PINS-1:0] irq_mode;
  logic [N_PINS-1:0]   irq_clr;
  logic [N_PINS-1:0]   pin_status;
  logic [N_PINS-1:0]   irq_stat;
  logic                irq;

  modport master (
    output pin_ctrl, pin_cfg, pwm_pin, dbg_pin, db_en, irq_en, irq_mode, irq_clr,
    input  pin_status, irq_stat, irq
  );

  modport slave (
    input  pin_ctrl, pin_cfg, pwm_pin, dbg_pin, db_en, irq_en, irq_mode, irq_clr,
    output pin_status, irq_stat, irq
  );
endinterface

// File: rtl/gpio_bank_pin_slice.sv
// One GPIO pin: registered mode mux onto the pad, synchroniser, debounce,
// edge detect and the sticky interrupt status bit.
module gpio_bank_pin_slice
  import gpio_bank_pkg::*;
#(
  parameter int N_PWM   = 8,
  parameter int DB_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire              pad_io,
  input  logic [3:0]       cfg_i,
  input  logic             ctrl_i,
  input  logic [N_PWM-1:0] pwm_i,
  input  logic             dbg_i,
  input  logic             db_en_i,
  input  logic             irq_en_i,
  input  logic [1:0]       irq_mode_i,
  input  logic             irq_clr_i,
  output logic             status_o,
  output logic             irq_stat_o
);

  localparam logic [DB_BITS-1:0] DB_MAX = '1;

  logic [3:0]         cfg_p1;
  logic               ctrl_p1;
  logic               oe_l_d, oe_l_q;
  logic               out_d, out_q;
  logic               s1_q, s2_q;
  logic               st_q, st_p1;
  logic [DB_BITS-1:0] cnt_q;
  logic               rise, fall;
  logic               stat_d, stat_q;

  // Stage p1: capture the register-file view of the pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_p1  <= CFG_IN;
      ctrl_p1 <= 1'b0;
    end else begin
      cfg_p1  <= cfg_i;
      ctrl_p1 <= ctrl_i;
    end
  end

  always_comb begin
    oe_l_d = 1'b1;
    out_d  = 1'b0;
    case (cfg_p1)
      CFG_IN:    oe_l_d = 1'b1;
      CFG_TOTEM: begin oe_l_d = 1'b0;     out_d = ctrl_p1; end
      CFG_OD:    oe_l_d = ctrl_p1;
      CFG_WOR:   begin oe_l_d = ~ctrl_p1; out_d = 1'b1;    end
      CFG_DBG:   begin oe_l_d = 1'b0;     out_d = dbg_i;   end
      default: begin
        if (cfg_p1[3]) begin
          // PWM selects beyond the implemented sources actively drive 0
          oe_l_d = 1'b0;
          for (int k = 0; k < N_PWM; k++)
            if (cfg_p1[2:0] == 3'(k)) out_d = pwm_i[k];
        end else begin
          out_d = 1'b1;
        end
      end
    endcase
  end

  // Stage p2: pad drive registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe_l_q <= 1'b1;
      out_q  <= 1'b0;
    end else begin
      oe_l_q <= oe_l_d;
      out_q  <= out_d;
    end
  end

  assign pad_io = oe_l_q ? 1'bz : out_q;

  // Input path: two-flop synchroniser then debounce
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      st_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= pad_io;
      s2_q <= s1_q;
      if (!db_en_i) begin
        st_q  <= s2_q;
        cnt_q <= '0;
      end else if (s2_q == st_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_MAX) begin
        st_q  <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise   = st_q & ~st_p1;
  assign fall   = ~st_q & st_p1;
  // A new edge outranks a simultaneous clear so no event is lost
  assign stat_d = (irq_en_i && edge_hit(irq_mode_i, rise, fall)) | (stat_q & ~irq_clr_i);

  // Edge detect stage and sticky status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_p1  <= 1'b0;
      stat_q <= 1'b0;
    end else begin
      st_p1  <= st_q;
      stat_q <= stat_d;
    end
  end

  assign status_o   = st_q;
  assign irq_stat_o = stat_q;

endmodule

// File: rtl/gpio_bank.sv
// N-pin GPIO bank: one pin slice per pad plus the registered bank interrupt.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int N_PINS  = 8,
  parameter int N_PWM   = 8,
  parameter int DB_BITS = 4
) (
  input  logic              reset,
  input  logic              clk,
  inout  wire  [N_PINS-1:0] gpio_pin,
  gpio_bank_if.slave        bus
);

  logic [N_PINS-1:0] status_w;
  logic [N_PINS-1:0] stat_w;
  logic              irq_q;

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    gpio_bank_pin_slice #(
      .N_PWM   (N_PWM),
      .DB_BITS (DB_BITS)
    ) u_slice (
      .clk        (clk),
      .reset      (reset),
      .pad_io     (gpio_pin[i]),
      .cfg_i      (bus.pin_cfg[4*i +: 4]),
      .ctrl_i     (bus.pin_ctrl[i]),
      .pwm_i      (bus.pwm_pin),
      .dbg_i      (bus.dbg_pin),
      .db_en_i    (bus.db_en[i]),
      .irq_en_i   (bus.irq_en[i]),
      .irq_mode_i (bus.irq_mode[2*i +: 2]),
      .irq_clr_i  (bus.irq_clr[i]),
      .status_o   (status_w[i]),
      .irq_stat_o (stat_w[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= |stat_w;
  end

  assign bus.pin_status = status_w;
  assign bus.irq_stat   = stat_w;
  assign bus.irq        = irq_q;

endmodule
